// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared state encodings, widths and BCD increment helper
package game_sequencer_pkg;

   localparam int STATE_W = 3;
   localparam int SCORE_W = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_PAUSE = 3'd2,
      ST_HIT   = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   // Increment a 4-digit BCD word with per-digit carry; 9999 holds instead of wrapping.
   function automatic logic [SCORE_W-1:0] bcd_inc_sat(input logic [SCORE_W-1:0] v);
      logic [SCORE_W-1:0] r;
      logic               carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      if (v == 16'h9999) begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - control inputs and display/status outputs of the game sequencer
interface game_sequencer_if;
   import game_sequencer_pkg::*;

   logic               i_start;
   logic               i_pause;
   logic               i_collision;
   logic               o_move_en;
   logic [STATE_W-1:0] o_state;
   logic [SCORE_W-1:0] o_score;
   logic [3:0]         o_lives;
   logic               o_game_over;
   logic [SCORE_W-1:0] o_hiscore;

   modport master (
      output i_start, i_pause, i_collision,
      input  o_move_en, o_state, o_score, o_lives, o_game_over, o_hiscore
   );

   modport slave (
      input  i_start, i_pause, i_collision,
      output o_move_en, o_state, o_score, o_lives, o_game_over, o_hiscore
   );
endinterface

// File: rtl/game_sequencer_bcd_counter4.sv
// rtl/game_sequencer_bcd_counter4.sv - 4-digit BCD counter with clear, saturating at 9999
module bcd_counter4
   import game_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic               i_inc,
   output logic [SCORE_W-1:0] o_value
);

   logic [SCORE_W-1:0] r_value;

   // Clear wins over increment so a new game always starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= '0;
      end else if (i_clr) begin
         r_value <= '0;
      end else if (i_inc) begin
         r_value <= bcd_inc_sat(r_value);
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game FSM, movement tick, score and lives; HISCORE_EN adds best-score register
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int TICK_DIV      = 1048576,
   parameter int LIVES_INIT    = 3,
   parameter int RESPAWN_TICKS = 64,
   parameter int SCORE_PERIOD  = 32
)(
   input  logic clk,
   input  logic rst,
   game_sequencer_if.slave bus
);

   localparam int TW  = $clog2(TICK_DIV);
   localparam int SCW = (SCORE_PERIOD  > 1) ? $clog2(SCORE_PERIOD)  : 1;
   localparam int RW  = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

   logic [TW-1:0]      r_tick_cnt;
   logic               w_tick;
   state_t             r_state;
   state_t             w_state_next;
   logic [3:0]         r_lives;
   logic [3:0]         w_lives_next;
   logic [SCW-1:0]     r_score_cnt;
   logic [SCW-1:0]     w_score_cnt_next;
   logic [RW-1:0]      r_resp_cnt;
   logic [RW-1:0]      w_resp_cnt_next;
   logic               w_score_clr;
   logic               w_score_inc;
   logic [SCORE_W-1:0] w_score;

   // Free-running divider; never reset by state changes so the tick period stays fixed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

   // State, lives and the two tick sub-counters advance together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_lives     <= '0;
         r_score_cnt <= '0;
         r_resp_cnt  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_lives     <= w_lives_next;
         r_score_cnt <= w_score_cnt_next;
         r_resp_cnt  <= w_resp_cnt_next;
      end
   end

   // Next-state rules; in PLAY a collision on a tick outranks pause.
   always_comb begin
      w_state_next     = r_state;
      w_lives_next     = r_lives;
      w_score_cnt_next = r_score_cnt;
      w_resp_cnt_next  = r_resp_cnt;
      w_score_clr      = 1'b0;
      w_score_inc      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_start) begin
               w_state_next     = ST_PLAY;
               w_lives_next     = 4'(LIVES_INIT);
               w_score_cnt_next = '0;
               w_resp_cnt_next  = '0;
               w_score_clr      = 1'b1;
            end
         end
         ST_PLAY: begin
            if (w_tick && bus.i_collision) begin
               if (r_lives <= 4'd1) begin
                  w_state_next = ST_OVER;
                  w_lives_next = '0;
               end else begin
                  w_state_next    = ST_HIT;
                  w_lives_next    = r_lives - 4'd1;
                  w_resp_cnt_next = '0;
               end
            end else begin
               if (w_tick) begin
                  if (r_score_cnt == SCW'(SCORE_PERIOD - 1)) begin
                     w_score_cnt_next = '0;
                     w_score_inc      = 1'b1;
                  end else begin
                     w_score_cnt_next = r_score_cnt + SCW'(1);
                  end
               end
               if (bus.i_pause) begin
                  w_state_next = ST_PAUSE;
               end
            end
         end
         ST_PAUSE: begin
            if (bus.i_pause) begin
               w_state_next = ST_PLAY;
            end
         end
         ST_HIT: begin
            if (w_tick) begin
               if (r_resp_cnt == RW'(RESPAWN_TICKS - 1)) begin
                  w_resp_cnt_next = '0;
                  w_state_next    = ST_PLAY;
               end else begin
                  w_resp_cnt_next = r_resp_cnt + RW'(1);
               end
            end
         end
         ST_OVER: begin
            if (bus.i_start) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   bcd_counter4 u_score (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_score_clr),
      .i_inc   (w_score_inc),
      .o_value (w_score)
   );

`ifdef HISCORE_EN
   logic               w_over_edge;
   logic [SCORE_W-1:0] r_hiscore;

   assign w_over_edge = (r_state == ST_PLAY) && (w_state_next == ST_OVER);

   // Capture the finishing score when it beats the best; BCD orders like binary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hiscore <= '0;
      end else if (w_over_edge && (w_score > r_hiscore)) begin
         r_hiscore <= w_score;
      end
   end

   assign bus.o_hiscore = r_hiscore;
`else
   assign bus.o_hiscore = '0;
`endif

   assign bus.o_move_en   = w_tick && (r_state == ST_PLAY);
   assign bus.o_state     = r_state;
   assign bus.o_score     = w_score;
   assign bus.o_lives     = r_lives;
   assign bus.o_game_over = (r_state == ST_OVER);

endmodule
